tile_map_renderer: RTL and testbench
====================================

TILE_MAP_RENDERER -- requirements
Module: tile_map_renderer

Interface
REQ-001 Parameter MAP_COLS, 32, tile-map width in tiles (power of two; column index wraps modulo MAP_COLS).
REQ-002 Parameter SCR_COLS, 20, visible tile columns (160 px / 8).
REQ-003 Parameter SCR_ROWS, 15, visible tile rows (120 px / 8).
REQ-004 Parameter TILE_PX, 8, tile edge in pixels.
REQ-005 Clock  in  1  single system clock; all state changes on rising edge.
REQ-006 Resetn  in  1  asynchronous, active-low reset.
REQ-007 Start  in  1  request to render one full frame; sampled only in IDLE.
REQ-008 Scroll  in  5  horizontal map-column offset; latched when Start is accepted.
REQ-009 MapAddress  out  9  tile-map RAM address = row*MAP_COLS + ((col+scroll) mod MAP_COLS).
REQ-010 MapData  in  4  tile index from map RAM; valid one cycle after MapAddress.
REQ-011 TileX  out  8  pixel X of current tile = col*TILE_PX.
REQ-012 TileY  out  7  pixel Y of current tile = row*TILE_PX.
REQ-013 TileSel  out  4  registered tile index for the tile drawer.
REQ-014 TileEnable  out  1  one-cycle request to the tile drawer.
REQ-015 TileDone  in  1  tile drawer idle/finished level (high = idle).
REQ-016 Busy  out  1  high from Start acceptance until FrameDone.
REQ-017 FrameDone  out  1  one-cycle pulse after the last tile completes.

Function
REQ-018 States: IDLE, FETCH, LATCH, ISSUE, WAIT_ACK, WAIT_DONE, NEXT, FINISH.
REQ-019 IDLE: Start=1 -> latch Scroll, clear col/row to 0, Busy=1, go FETCH; Start otherwise ignored (also ignored while Busy).
REQ-020 FETCH: drive MapAddress for (row, col); go LATCH.
REQ-021 LATCH: register MapData into TileSel; go ISSUE.
REQ-022 ISSUE: hold until TileDone=1; in the cycle TileDone=1, TileEnable=1 for exactly that cycle; go WAIT_ACK.
REQ-023 WAIT_ACK: wait for TileDone=0 (drawer accepted); go WAIT_DONE.
REQ-024 WAIT_DONE: wait for TileDone=1; go NEXT.
REQ-025 NEXT: col = SCR_COLS-1 -> col=0, row+1; else col+1. If (row, col) was (SCR_ROWS-1, SCR_COLS-1), go FINISH; otherwise go FETCH.
REQ-026 FINISH: FrameDone=1 for one cycle, Busy=0 next cycle; go IDLE.
REQ-027 TileX, TileY, TileSel stable from LATCH through WAIT_DONE inclusive.
REQ-028 Column wrap: (col+scroll) computed 5-bit, so carry is discarded (e.g. col 19, scroll 20 -> map col 7).
REQ-029 Exactly SCR_COLS*SCR_ROWS = 300 TileEnable pulses per frame; row-major order.
REQ-030 Changes to Scroll while Busy have no effect on the current frame.
REQ-031 TileDone low at ISSUE entry (drawer still in its post-reset START state) stalls without issuing.

Reset
REQ-032 Resetn=0 asynchronously forces IDLE, col=row=0, scroll latch=0, TileSel=0, MapAddress=0, TileEnable=0, Busy=0, FrameDone=0.
REQ-033 Reset mid-frame aborts the frame with no FrameDone; the next frame starts only on a new Start.

Structure
REQ-034 Shared package holds MAP_COLS, SCR_COLS, SCR_ROWS, TILE_PX defaults and the state encoding.
REQ-035 One sub-module, tile_cursor: col/row counters with wrap and last-cell flag; the FSM and address/pixel arithmetic stay in the top module.

Verification
REQ-036 Reset, Start with Scroll=0, drawer model (Done drops 1 cycle after Enable, rises 64 cycles later) -> 300 TileEnable pulses, first at TileX=0/TileY=0, last at TileX=152/TileY=112, one FrameDone.
REQ-037 Scroll=20, map RAM holds column index mod 16 -> row 0 col 19 issues TileSel=7 from MapAddress=7.
REQ-038 Start pulsed again mid-frame, with Scroll changed -> no restart, addresses still use the first latched Scroll, single FrameDone.
REQ-039 TileDone held low 10 cycles at the first ISSUE -> TileEnable withheld until TileDone=1, then exactly one pulse.
REQ-040 Resetn asserted at tile 150 -> outputs zero immediately, no FrameDone; new Start renders a full 300-tile frame.
REQ-041 Row boundary: after tile (row 0, col 19) -> next MapAddress=32 (row 1, col 0, Scroll=0), TileY=8.

Source files
------------

// File: rtl/tile_map_renderer_pkg.sv
// Shared constants and the FSM state encoding for the tile map renderer.
package tile_map_renderer_pkg;

    localparam int MAP_COLS_DEF = 32;
    localparam int SCR_COLS_DEF = 20;
    localparam int SCR_ROWS_DEF = 15;
    localparam int TILE_PX_DEF  = 8;

    localparam int COL_W   = 5;
    localparam int ROW_W   = 4;
    localparam int ADDR_W  = 9;
    localparam int TILEX_W = 8;
    localparam int TILEY_W = 7;
    localparam int SEL_W   = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LATCH,
        ST_ISSUE,
        ST_WAIT_ACK,
        ST_WAIT_DONE,
        ST_NEXT,
        ST_FINISH
    } render_state_t;

endpackage

// File: rtl/tile_map_renderer_if.sv
// Bundle of the frame-control, map-RAM and tile-drawer signals of the renderer.
interface tile_map_renderer_if;
    import tile_map_renderer_pkg::*;

    logic               Start;
    logic [COL_W-1:0]   Scroll;
    logic [ADDR_W-1:0]  MapAddress;
    logic [SEL_W-1:0]   MapData;
    logic [TILEX_W-1:0] TileX;
    logic [TILEY_W-1:0] TileY;
    logic [SEL_W-1:0]   TileSel;
    logic               TileEnable;
    logic               TileDone;
    logic               Busy;
    logic               FrameDone;

    // The renderer side
    modport master (
        input  Start, Scroll, MapData, TileDone,
        output MapAddress, TileX, TileY, TileSel, TileEnable, Busy, FrameDone
    );

    // The surrounding system: frame requester, map RAM and tile drawer
    modport slave (
        output Start, Scroll, MapData, TileDone,
        input  MapAddress, TileX, TileY, TileSel, TileEnable, Busy, FrameDone
    );

endinterface

// File: rtl/tile_cursor.sv
// Row-major screen cursor: walks (row, col) over the visible tile grid and
// flags the final cell. Exposes the post-advance position so the renderer
// can precompute the next address while still sitting on the current tile.
module tile_cursor
    import tile_map_renderer_pkg::*;
#(
    parameter int SCR_COLS = SCR_COLS_DEF,
    parameter int SCR_ROWS = SCR_ROWS_DEF
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             clear,
    input  logic             advance,
    output logic [COL_W-1:0] col_next,
    output logic [ROW_W-1:0] row_next,
    output logic             last_cell
);

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             row_end;

    assign row_end   = (col == COL_W'(SCR_COLS - 1));
    assign last_cell = row_end && (row == ROW_W'(SCR_ROWS - 1));

    // Next position: step along the row, wrap to the next row, and return to
    // the origin after the last cell so the cursor is parked cleanly.
    always_comb begin
        col_next = col + COL_W'(1);
        row_next = row;
        if (row_end) begin
            col_next = '0;
            row_next = last_cell ? '0 : row + ROW_W'(1);
        end
    end

    // Cursor registers; a clear (frame start) takes priority over advancing.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            col <= '0;
            row <= '0;
        end else if (clear) begin
            col <= '0;
            row <= '0;
        end else if (advance) begin
            col <= col_next;
            row <= row_next;
        end
    end

endmodule

// File: rtl/tile_map_renderer.sv
// Tile map renderer: walks every visible tile of a horizontally scrolled tile
// map, reads each tile index from map RAM and hands it to a tile drawer one
// tile at a time using the drawer's Enable/Done handshake.
module tile_map_renderer
    import tile_map_renderer_pkg::*;
#(
    parameter int MAP_COLS = MAP_COLS_DEF,
    parameter int SCR_COLS = SCR_COLS_DEF,
    parameter int SCR_ROWS = SCR_ROWS_DEF,
    parameter int TILE_PX  = TILE_PX_DEF
) (
    input  logic               Clock,
    input  logic               Resetn,
    tile_map_renderer_if.master bus
);

    render_state_t      state;
    logic [COL_W-1:0]   scroll_q;
    logic [ADDR_W-1:0]  map_address_q;
    logic [TILEX_W-1:0] tile_x_q;
    logic [TILEY_W-1:0] tile_y_q;
    logic [SEL_W-1:0]   tile_sel_q;
    logic               busy_q;
    logic               frame_done_q;

    logic               cursor_clear;
    logic               cursor_advance;
    logic [COL_W-1:0]   col_next;
    logic [ROW_W-1:0]   row_next;
    logic               last_cell;

    logic [COL_W-1:0]   map_col_next;
    logic [ADDR_W-1:0]  address_next;
    logic [TILEX_W-1:0] tile_x_next;
    logic [TILEY_W-1:0] tile_y_next;

    assign cursor_clear   = (state == ST_IDLE) && bus.Start;
    assign cursor_advance = (state == ST_NEXT);

    tile_cursor #(
        .SCR_COLS (SCR_COLS),
        .SCR_ROWS (SCR_ROWS)
    ) u_cursor (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .clear     (cursor_clear),
        .advance   (cursor_advance),
        .col_next  (col_next),
        .row_next  (row_next),
        .last_cell (last_cell)
    );

    // The map column is a 5-bit sum so the carry drops out, giving the
    // modulo-MAP_COLS horizontal wrap for free.
    assign map_col_next = col_next + scroll_q;
    assign address_next = ADDR_W'(row_next) * ADDR_W'(MAP_COLS) + ADDR_W'(map_col_next);
    assign tile_x_next  = TILEX_W'(col_next) * TILEX_W'(TILE_PX);
    assign tile_y_next  = TILEY_W'(row_next) * TILEY_W'(TILE_PX);

    // The drawer request must coincide with the cycle the drawer reports idle,
    // so it is decoded from the registered state rather than registered itself.
    assign bus.TileEnable = (state == ST_ISSUE) && bus.TileDone;

    assign bus.MapAddress = map_address_q;
    assign bus.TileX      = tile_x_q;
    assign bus.TileY      = tile_y_q;
    assign bus.TileSel    = tile_sel_q;
    assign bus.Busy       = busy_q;
    assign bus.FrameDone  = frame_done_q;

    // Frame sequencer with its registered outputs; address and pixel position
    // are loaded on entry to FETCH and held until the tile has been drawn.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state         <= ST_IDLE;
            scroll_q      <= '0;
            map_address_q <= '0;
            tile_x_q      <= '0;
            tile_y_q      <= '0;
            tile_sel_q    <= '0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.Start) begin
                        scroll_q      <= bus.Scroll;
                        map_address_q <= ADDR_W'(bus.Scroll);
                        tile_x_q      <= '0;
                        tile_y_q      <= '0;
                        busy_q        <= 1'b1;
                        state         <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    state <= ST_LATCH;
                end
                ST_LATCH: begin
                    tile_sel_q <= bus.MapData;
                    state      <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (bus.TileDone) begin
                        state <= ST_WAIT_ACK;
                    end
                end
                ST_WAIT_ACK: begin
                    if (!bus.TileDone) begin
                        state <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (bus.TileDone) begin
                        state <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    if (last_cell) begin
                        frame_done_q <= 1'b1;
                        state        <= ST_FINISH;
                    end else begin
                        map_address_q <= address_next;
                        tile_x_q      <= tile_x_next;
                        tile_y_q      <= tile_y_next;
                        state         <= ST_FETCH;
                    end
                end
                ST_FINISH: begin
                    frame_done_q <= 1'b0;
                    busy_q       <= 1'b0;
                    state        <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tile_map_renderer.sv
// Self-checking bench for tile_map_renderer: a map RAM and tile drawer model
// drive the DUT, and every issued tile is compared against an expected frame
// computed directly from the row-major / scroll-wrap rules.
module tb_tile_map_renderer;
    import tile_map_renderer_pkg::*;

    localparam int NUM_COLS  = 20;
    localparam int NUM_ROWS  = 15;
    localparam int NUM_TILES = NUM_COLS * NUM_ROWS;

    typedef struct {
        logic [8:0] addr;
        logic [7:0] x;
        logic [6:0] y;
        logic [3:0] sel;
    } tile_t;

    typedef struct {
        logic [4:0] scroll;
        int         ramMode;
        int         latency;
        int         expPulses;
        int         expFrameDones;
        int         expLastX;
        int         expLastY;
    } frameVec_t;

    logic Clock  = 1'b0;
    logic Resetn = 1'b0;

    tile_map_renderer_if bus();

    tile_map_renderer #(
        .MAP_COLS (32),
        .SCR_COLS (20),
        .SCR_ROWS (15),
        .TILE_PX  (8)
    ) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .bus    (bus)
    );

    always #5 Clock = ~Clock;

    int checksRun      = 0;
    int checksPassed   = 0;
    int drawerLatency  = 64;
    int drawerHold     = 0;
    int drawerCount    = 0;
    int enableCount    = 0;
    int frameDoneCount = 0;

    logic [3:0] mapRam [512];
    tile_t      expQ[$];
    tile_t      seen[$];

    // Map RAM (one-cycle read latency) and tile drawer model: Done drops the
    // cycle after an Enable and rises drawerLatency cycles later; drawerHold
    // forces Done low to imitate a drawer that has not left its start state.
    initial begin
        logic       en;
        logic [8:0] addr;
        bus.TileDone = 1'b1;
        bus.MapData  = '0;
        forever begin
            @(posedge Clock);
            en   = bus.TileEnable;
            addr = bus.MapAddress;
            #1;
            bus.MapData = mapRam[addr];
            if (drawerHold > 0) begin
                drawerHold--;
                bus.TileDone = (drawerHold == 0);
            end else if (en) begin
                bus.TileDone = 1'b0;
                drawerCount  = drawerLatency;
            end else if (!bus.TileDone) begin
                drawerCount--;
                if (drawerCount <= 0) bus.TileDone = 1'b1;
            end
        end
    end

    // Record every issued tile and every frame-done pulse mid-cycle.
    always @(negedge Clock) begin
        if (Resetn) begin
            if (bus.TileEnable) begin
                seen.push_back('{bus.MapAddress, bus.TileX, bus.TileY, bus.TileSel});
                enableCount++;
            end
            if (bus.FrameDone) frameDoneCount++;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checksRun++;
        if (actual === expected) checksPassed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    function automatic logic [31:0] packTile(input tile_t t);
        return {4'b0, t.addr, t.x, t.y, t.sel};
    endfunction

    function automatic logic [31:0] packOutputs();
        return {bus.MapAddress, bus.TileX, bus.TileY, bus.TileSel,
                bus.TileEnable, bus.Busy, bus.FrameDone};
    endfunction

    task automatic fillRam(input int mode);
        for (int a = 0; a < 512; a++) begin
            if (mode == 0) mapRam[a] = 4'((a % 32) % 16);
            else           mapRam[a] = 4'($urandom);
        end
    endtask

    // Reference frame: row-major walk, map column = (col + scroll) mod 32.
    task automatic buildExpected(input int scroll);
        expQ.delete();
        for (int r = 0; r < NUM_ROWS; r++) begin
            for (int c = 0; c < NUM_COLS; c++) begin
                int mc;
                int a;
                mc = (c + scroll) % 32;
                a  = r * 32 + mc;
                expQ.push_back('{9'(a), 8'(c * 8), 7'(r * 8), mapRam[a]});
            end
        end
    endtask

    task automatic resetCapture();
        seen.delete();
        enableCount    = 0;
        frameDoneCount = 0;
    endtask

    task automatic pulseStart(input logic [4:0] scroll);
        @(negedge Clock);
        bus.Start  = 1'b1;
        bus.Scroll = scroll;
        @(negedge Clock);
        bus.Start  = 1'b0;
    endtask

    task automatic waitEnables(input int target, input int budget, input string name);
        int n = 0;
        while (enableCount < target && n < budget) begin
            @(negedge Clock);
            n++;
        end
        if (enableCount < target) checkOutput({name, "_reachTile"}, enableCount, target);
    endtask

    // Wait for the frame to finish, then allow a margin to catch a duplicate pulse.
    task automatic waitFrameDone(input int budget, input string name);
        int n = 0;
        while (frameDoneCount == 0 && n < budget) begin
            @(negedge Clock);
            n++;
        end
        checkOutput({name, "_frameDoneSeen"}, (frameDoneCount > 0), 1);
        repeat (5) @(negedge Clock);
        checkOutput({name, "_busyAfter"}, bus.Busy, 0);
    endtask

    task automatic compareFrame(input string name);
        int n;
        checkOutput({name, "_tileCount"}, seen.size(), NUM_TILES);
        n = (seen.size() < expQ.size()) ? seen.size() : expQ.size();
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("%s_tile%0d", name, i), packTile(seen[i]), packTile(expQ[i]));
        end
    endtask

    task automatic applyStimulus(input frameVec_t v, input string name);
        fillRam(v.ramMode);
        drawerLatency = v.latency;
        buildExpected(int'(v.scroll));
        resetCapture();
        pulseStart(v.scroll);
        checkOutput({name, "_busyAfterStart"}, bus.Busy, 1);
        waitFrameDone(NUM_TILES * (v.latency + 12) + 200, name);
        compareFrame(name);
        checkOutput({name, "_pulses"}, enableCount, v.expPulses);
        checkOutput({name, "_frameDones"}, frameDoneCount, v.expFrameDones);
        if (seen.size() == NUM_TILES) begin
            checkOutput({name, "_firstXY"}, {seen[0].x, seen[0].y}, 0);
            checkOutput({name, "_lastX"}, seen[NUM_TILES-1].x, v.expLastX);
            checkOutput({name, "_lastY"}, seen[NUM_TILES-1].y, v.expLastY);
        end
    endtask

    initial begin
        frameVec_t vecs[4];
        string     name;

        vecs[0] = '{5'd0,  0, 64, 300, 1, 152, 112};
        vecs[1] = '{5'd20, 0, 3,  300, 1, 152, 112};
        vecs[2] = '{5'($urandom_range(0, 31)), 1, 2, 300, 1, 152, 112};
        vecs[3] = '{5'($urandom_range(0, 31)), 1, int'($urandom_range(1, 6)), 300, 1, 152, 112};

        bus.Start  = 1'b0;
        bus.Scroll = '0;
        fillRam(0);

        // Reset state
        repeat (3) @(negedge Clock);
        checkOutput("resetOutputs", packOutputs(), 0);
        Resetn = 1'b1;
        repeat (3) @(negedge Clock);
        checkOutput("idleAfterReset", packOutputs(), 0);

        // Table-driven full frames
        for (int i = 0; i < 4; i++) begin
            name = $sformatf("frame%0d", i);
            $display("[TB] %s scroll=%0d latency=%0d", name, vecs[i].scroll, vecs[i].latency);
            applyStimulus(vecs[i], name);
            if (i == 0 && seen.size() > 20) begin
                checkOutput("rowBoundaryAddr", seen[20].addr, 32);
                checkOutput("rowBoundaryY", seen[20].y, 8);
                checkOutput("rowEndAddr", seen[19].addr, 19);
            end
            if (i == 1 && seen.size() > 19) begin
                checkOutput("scrollWrapAddr", seen[19].addr, 7);
                checkOutput("scrollWrapSel", seen[19].sel, 7);
            end
        end

        // Drawer not ready at the first ISSUE: no request until Done rises
        $display("[TB] stalled drawer sequence");
        fillRam(1);
        drawerLatency = 2;
        buildExpected(3);
        resetCapture();
        @(negedge Clock);
        bus.Start    = 1'b1;
        bus.Scroll   = 5'd3;
        bus.TileDone = 1'b0;
        drawerHold   = 14;
        @(negedge Clock);
        bus.Start = 1'b0;
        repeat (10) @(negedge Clock);
        checkOutput("stallNoEnable", enableCount, 0);
        checkOutput("stallBusy", bus.Busy, 1);
        waitFrameDone(NUM_TILES * 14 + 200, "stall");
        compareFrame("stall");
        checkOutput("stallFrameDones", frameDoneCount, 1);

        // Start and Scroll changes mid-frame are ignored
        $display("[TB] mid-frame restart sequence");
        fillRam(1);
        drawerLatency = 2;
        buildExpected(5);
        resetCapture();
        pulseStart(5'd5);
        waitEnables(50, 2000, "restart");
        pulseStart(5'd17);
        bus.Scroll = 5'd9;
        waitFrameDone(NUM_TILES * 14 + 200, "restart");
        compareFrame("restart");
        checkOutput("restartFrameDones", frameDoneCount, 1);

        // Reset in the middle of a frame aborts it without FrameDone
        $display("[TB] mid-frame reset sequence");
        fillRam(1);
        drawerLatency = 2;
        buildExpected(11);
        resetCapture();
        pulseStart(5'd11);
        waitEnables(150, 4000, "abort");
        @(negedge Clock);
        Resetn = 1'b0;
        #1;
        checkOutput("abortOutputsZero", packOutputs(), 0);
        begin
            int pulsesAtReset;
            pulsesAtReset = enableCount;
            repeat (3) @(negedge Clock);
            Resetn = 1'b1;
            repeat (30) @(negedge Clock);
            checkOutput("abortNoFrameDone", frameDoneCount, 0);
            checkOutput("abortIdle", bus.Busy, 0);
            checkOutput("abortNoNewTiles", enableCount, pulsesAtReset);
        end
        applyStimulus('{5'd11, 1, 2, 300, 1, 152, 112}, "afterAbort");

        $display("%0d/%0d checks passed", checksPassed, checksRun);
        $finish;
    end

endmodule
